// File: rtl/sata_link_rx_frame_fifo.sv
// Receive frame FIFO for the SATA link layer. Words become visible downstream only
// after their frame's eop commits; bad or overflowing frames are rolled back.
module sata_link_rx_frame_fifo #(
    parameter int DWIDTH       = 32,
    parameter int DEPTH        = 512,
    parameter int AFULL_MARGIN = 16,
    parameter int DROP_BAD     = 1,
    parameter int CNTW         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DWIDTH-1:0]        i_dat,
    input  logic                     i_val,
    input  logic                     i_eop,
    input  logic                     i_err,
    output logic [DWIDTH-1:0]        o_dat,
    output logic                     o_val,
    output logic                     o_eop,
    output logic                     o_err,
    input  logic                     o_rdy,
    output logic                     o_almostfull,
    output logic [$clog2(DEPTH):0]   o_frames,
    output logic                     stat_good_crc,
    output logic                     stat_bad_crc,
    output logic                     stat_fifo_ovfl,
    output logic [CNTW-1:0]          cnt_good,
    output logic [CNTW-1:0]          cnt_bad,
    output logic [CNTW-1:0]          cnt_ovfl,
    input  logic                     stat_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DWIDTH + 2;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_TH = PW'(DEPTH - AFULL_MARGIN);
    localparam logic [PW-1:0] ONE_P    = PW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DISCARD} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   commit_ptr_reg, commit_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   fill_next;
    logic [PW-1:0]   frames_reg;
    logic            afull_reg;
    logic            full;
    logic            wr_en, commit_evt, rd_evt, rd_eop;
    logic            good_next, bad_next, ovfl_next;
    logic [2:0]      ev_next;
    logic [2:0]      pulse_reg;
    logic [CNTW-1:0] cnt_reg [3];
    logic [EW-1:0]   mem [DEPTH];

    // Full uses registered pointers only, so a same-cycle read never frees a slot for the write.
    assign full = ((wr_ptr_reg - rd_ptr_reg) == DEPTH_P);

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        wr_en           = 1'b0;
        commit_evt      = 1'b0;
        good_next       = 1'b0;
        bad_next        = 1'b0;
        ovfl_next       = 1'b0;
        case (state_reg)
            ST_IDLE, ST_RECV: begin
                if (i_val) begin
                    if (full) begin
                        ovfl_next   = 1'b1;
                        wr_ptr_next = commit_ptr_reg;
                        state_next  = i_eop ? ST_IDLE : ST_DISCARD;
                    end else if (i_eop && i_err && (DROP_BAD != 0)) begin
                        bad_next    = 1'b1;
                        wr_ptr_next = commit_ptr_reg;
                        state_next  = ST_IDLE;
                    end else begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr_reg + ONE_P;
                        if (i_eop) begin
                            commit_ptr_next = wr_ptr_reg + ONE_P;
                            commit_evt      = 1'b1;
                            good_next       = !i_err;
                            bad_next        = i_err;
                            state_next      = ST_IDLE;
                        end else begin
                            state_next = ST_RECV;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (i_val && i_eop) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_val  = (rd_ptr_reg != commit_ptr_reg);
    assign {o_dat, o_eop, o_err} = mem[rd_ptr_reg[AW-1:0]];
    assign rd_evt = o_val && o_rdy;
    assign rd_eop = rd_evt && o_eop;
    assign rd_ptr_next = rd_evt ? (rd_ptr_reg + ONE_P) : rd_ptr_reg;
    assign fill_next   = wr_ptr_next - rd_ptr_next;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= {i_dat, i_eop, i_err};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            rd_ptr_reg     <= '0;
            afull_reg      <= 1'b0;
            frames_reg     <= '0;
            pulse_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            commit_ptr_reg <= commit_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            afull_reg      <= (fill_next >= AFULL_TH);
            pulse_reg      <= ev_next;
            if (commit_evt && !rd_eop) begin
                frames_reg <= frames_reg + ONE_P;
            end else if (!commit_evt && rd_eop) begin
                frames_reg <= frames_reg - ONE_P;
            end
        end
    end

    assign ev_next = {ovfl_next, bad_next, good_next};

    // Counters step with the same edge that raises their pulse; a clear overrides the step.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_reg[gi] <= '0;
            end else if (stat_clr) begin
                cnt_reg[gi] <= '0;
            end else if (ev_next[gi] && (cnt_reg[gi] != {CNTW{1'b1}})) begin
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    end

    assign o_almostfull   = afull_reg;
    assign o_frames       = frames_reg;
    assign stat_good_crc  = pulse_reg[0];
    assign stat_bad_crc   = pulse_reg[1];
    assign stat_fifo_ovfl = pulse_reg[2];
    assign cnt_good       = cnt_reg[0];
    assign cnt_bad        = cnt_reg[1];
    assign cnt_ovfl       = cnt_reg[2];

endmodule

// File: tb/tb_sata_link_rx_frame_fifo.sv
// Scoreboard bench: two FIFO instances (drop-bad and keep-bad) share one input stream;
// a negedge monitor pops expected words whenever a word is accepted downstream.
module tb_sata_link_rx_frame_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_dat;
    logic        i_val, i_eop, i_err, o_rdy, stat_clr;

    logic [31:0] o_dat_d, o_dat_k;
    logic        o_val_d, o_eop_d, o_err_d, afull_d;
    logic        o_val_k, o_eop_k, o_err_k, afull_k;
    logic [3:0]  frames_d, frames_k;
    logic        good_d, bad_d, ovfl_d, good_k, bad_k, ovfl_k;
    logic [15:0] cnt_good_d, cnt_bad_d, cnt_ovfl_d, cnt_good_k, cnt_bad_k, cnt_ovfl_k;

    int n_checks = 0;
    int n_fail   = 0;
    int tg_d = 0, tb_d = 0, to_d = 0, tg_k = 0, tb_k = 0, to_k = 0;
    logic [33:0] q_d[$];
    logic [33:0] q_k[$];

    always #5 clk = ~clk;

    sata_link_rx_frame_fifo #(.DWIDTH(32), .DEPTH(8), .AFULL_MARGIN(2), .DROP_BAD(1), .CNTW(16)) u_dut_drop (
        .clk(clk), .reset(reset),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_err(i_err),
        .o_dat(o_dat_d), .o_val(o_val_d), .o_eop(o_eop_d), .o_err(o_err_d),
        .o_rdy(o_rdy), .o_almostfull(afull_d), .o_frames(frames_d),
        .stat_good_crc(good_d), .stat_bad_crc(bad_d), .stat_fifo_ovfl(ovfl_d),
        .cnt_good(cnt_good_d), .cnt_bad(cnt_bad_d), .cnt_ovfl(cnt_ovfl_d),
        .stat_clr(stat_clr)
    );

    sata_link_rx_frame_fifo #(.DWIDTH(32), .DEPTH(8), .AFULL_MARGIN(2), .DROP_BAD(0), .CNTW(16)) u_dut_keep (
        .clk(clk), .reset(reset),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_err(i_err),
        .o_dat(o_dat_k), .o_val(o_val_k), .o_eop(o_eop_k), .o_err(o_err_k),
        .o_rdy(o_rdy), .o_almostfull(afull_k), .o_frames(frames_k),
        .stat_good_crc(good_k), .stat_bad_crc(bad_k), .stat_fifo_ovfl(ovfl_k),
        .cnt_good(cnt_good_k), .cnt_bad(cnt_bad_k), .cnt_ovfl(cnt_ovfl_k),
        .stat_clr(stat_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one line per accepted output word.
    always @(negedge clk) begin : monitor
        logic [33:0] e;
        if (reset) begin
            if (o_val_d && o_rdy) begin
                if (q_d.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL drop_out: got unexpected word %0h expected none", o_dat_d);
                end else begin
                    e = q_d.pop_front();
                    $display("drop out: dat=%h eop=%0b err=%0b exp=%h", o_dat_d, o_eop_d, o_err_d, e);
                    check("drop_out", {o_dat_d, o_eop_d, o_err_d}, e);
                end
            end
            if (o_val_k && o_rdy) begin
                if (q_k.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL keep_out: got unexpected word %0h expected none", o_dat_k);
                end else begin
                    e = q_k.pop_front();
                    $display("keep out: dat=%h eop=%0b err=%0b exp=%h", o_dat_k, o_eop_k, o_err_k, e);
                    check("keep_out", {o_dat_k, o_eop_k, o_err_k}, e);
                end
            end
        end
        tg_d += int'(good_d); tb_d += int'(bad_d); to_d += int'(ovfl_d);
        tg_k += int'(good_k); tb_k += int'(bad_k); to_k += int'(ovfl_k);
    end

    task automatic send(input logic [31:0] base, input int len, input logic err_last, input bit eop_last);
        for (int i = 0; i < len; i++) begin
            i_dat = base + 32'(i);
            i_val = 1'b1;
            i_eop = (i == len - 1) && eop_last;
            i_err = i_eop && err_last;
            @(posedge clk); #1;
        end
        i_val = 1'b0; i_eop = 1'b0; i_err = 1'b0;
    endtask

    task automatic push(input bit to_d, input bit to_k, input logic [31:0] base, input int len, input logic err_last);
        for (int i = 0; i < len; i++) begin
            if (to_d) q_d.push_back({base + 32'(i), i == len - 1, (i == len - 1) && err_last});
            if (to_k) q_k.push_back({base + 32'(i), i == len - 1, (i == len - 1) && err_last});
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; i_dat = '0; i_val = 1'b0; i_eop = 1'b0; i_err = 1'b0;
        o_rdy = 1'b0; stat_clr = 1'b0;
        cycles(3);
        check("rst_o_val", o_val_d, 1'b0);
        check("rst_frames", frames_d, 4'd0);
        check("rst_afull", afull_d, 1'b0);
        check("rst_cnt_good", cnt_good_d, 16'd0);
        reset = 1'b1;
        cycles(2);

        // Good 4-word frame, downstream ready
        o_rdy = 1'b1;
        push(1, 1, 32'h1000_0000, 4, 1'b0);
        send(32'h1000_0000, 3, 1'b0, 1'b0);
        check("t1_uncommitted_hidden", o_val_d, 1'b0);
        send(32'h1000_0003, 1, 1'b0, 1'b1);
        check("t1_o_val_after_eop", o_val_d, 1'b1);
        check("t1_frames_one", frames_d, 4'd1);
        check("t1_good_pulse", good_d, 1'b1);
        cycles(4);
        check("t1_frames_zero", frames_d, 4'd0);
        check("t1_o_val_empty", o_val_d, 1'b0);
        check("t1_cnt_good", cnt_good_d, 16'd1);
        check("t1_good_tally", tg_d, 1);

        // Bad 3-word frame then good 2-word frame
        push(0, 1, 32'h2000_0000, 3, 1'b1);
        push(1, 1, 32'h2100_0000, 2, 1'b0);
        send(32'h2000_0000, 3, 1'b1, 1'b1);
        check("t2_bad_pulse", bad_d, 1'b1);
        check("t2_drop_no_val", o_val_d, 1'b0);
        send(32'h2100_0000, 2, 1'b0, 1'b1);
        cycles(8);
        check("t2_cnt_bad_drop", cnt_bad_d, 16'd1);
        check("t2_cnt_bad_keep", cnt_bad_k, 16'd1);
        check("t2_cnt_good_drop", cnt_good_d, 16'd2);
        check("t2_cnt_good_keep", cnt_good_k, 16'd2);
        check("t2_frames_keep", frames_k, 4'd0);

        // Overflow: 10-word frame into 8 entries, then a 4-word frame
        o_rdy = 1'b0;
        push(1, 1, 32'h3100_0000, 4, 1'b0);
        send(32'h3000_0000, 9, 1'b0, 1'b0);
        check("t3_ovfl_pulse", ovfl_d, 1'b1);
        send(32'h3000_0009, 1, 1'b0, 1'b1);
        check("t3_ovfl_one_cycle", ovfl_d, 1'b0);
        check("t3_discarded_hidden", o_val_d, 1'b0);
        send(32'h3100_0000, 4, 1'b0, 1'b1);
        check("t3_frames_drop", frames_d, 4'd1);
        check("t3_frames_keep", frames_k, 4'd1);
        check("t3_cnt_ovfl", cnt_ovfl_d, 16'd1);
        check("t3_ovfl_tally", to_d, 1);
        o_rdy = 1'b1;
        cycles(6);
        check("t3_frames_drained", frames_d, 4'd0);

        // Almost-full threshold at 6 of 8
        o_rdy = 1'b0;
        push(1, 1, 32'h4000_0000, 6, 1'b0);
        send(32'h4000_0000, 5, 1'b0, 1'b0);
        check("t4_afull_at5", afull_d, 1'b0);
        send(32'h4000_0005, 1, 1'b0, 1'b1);
        check("t4_afull_at6_drop", afull_d, 1'b1);
        check("t4_afull_at6_keep", afull_k, 1'b1);
        o_rdy = 1'b1;
        cycles(1);
        o_rdy = 1'b0;
        check("t4_afull_after_read", afull_d, 1'b0);
        o_rdy = 1'b1;
        cycles(7);
        check("t4_o_val_empty", o_val_d, 1'b0);
        check("t4_frames_zero", frames_k, 4'd0);

        // Counter clear
        check("clr_pre_good", cnt_good_d, 16'd4);
        check("clr_pre_good_keep", cnt_good_k, 16'd4);
        stat_clr = 1'b1;
        cycles(1);
        stat_clr = 1'b0;
        check("clr_good", cnt_good_d, 16'd0);
        check("clr_bad", cnt_bad_k, 16'd0);
        check("clr_ovfl", cnt_ovfl_d, 16'd0);

        // Reset mid-frame with a committed frame still pending
        o_rdy = 1'b0;
        send(32'h5F00_0000, 1, 1'b0, 1'b1);
        check("t5_frames_pre", frames_d, 4'd1);
        send(32'h5000_0000, 2, 1'b0, 1'b0);
        reset = 1'b0;
        #2;
        check("t5_rst_o_val", o_val_d, 1'b0);
        check("t5_rst_frames", frames_d, 4'd0);
        check("t5_rst_cnt", cnt_good_d, 16'd0);
        cycles(2);
        reset = 1'b1;
        cycles(1);
        o_rdy = 1'b1;
        push(1, 1, 32'h5100_0000, 3, 1'b0);
        send(32'h5100_0000, 3, 1'b0, 1'b1);
        cycles(6);
        check("t5_cnt_good", cnt_good_d, 16'd1);
        check("t5_frames_zero", frames_d, 4'd0);

        check("end_good_tally_drop", tg_d, 6);
        check("end_good_tally_keep", tg_k, 6);
        check("end_bad_tally_drop", tb_d, 1);
        check("end_ovfl_tally_keep", to_k, 1);
        check("end_q_drop_empty", q_d.size(), 0);
        check("end_q_keep_empty", q_k.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sata_link_rx_frame_fifo.md
SATA_LINK_RX_FRAME_FIFO -- requirements
Module: sata_link_rx_frame_fifo

Interface
REQ-001 Parameter DWIDTH, 32, data word width in bits.
REQ-002 Parameter DEPTH, 512, storage depth in words; power of 2, >=4.
REQ-003 Parameter AFULL_MARGIN, 16, free-word threshold for o_almostfull; 1..DEPTH-1.
REQ-004 Parameter DROP_BAD, 1, 1 = discard frames whose eop word has i_err=1; 0 = deliver them with o_err=1 on eop.
REQ-005 Parameter CNTW, 16, width of the statistics counters.
REQ-006 Port clk  in  1  single clock; all logic on its rising edge.
REQ-007 Port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 Port i_dat/i_val/i_eop/i_err  in  DWIDTH/1/1/1  post-CRC-check stream; no ready signal, a word is presented on every cycle that i_val=1.
REQ-009 Port o_dat/o_val/o_eop/o_err  out  DWIDTH/1/1/1  committed-frame output stream.
REQ-010 Port o_rdy  in  1  downstream accepts the word on a cycle where o_val=1 and o_rdy=1.
REQ-011 Port o_almostfull  out  1  registered; used to raise HOLD upstream.
REQ-012 Port o_frames  out  log2(DEPTH)+1  number of complete committed frames not yet fully read.
REQ-013 Port stat_good_crc/stat_bad_crc/stat_fifo_ovfl  out  1 each  one-cycle event pulses.
REQ-014 Port cnt_good/cnt_bad/cnt_ovfl  out  CNTW each  saturating event counters.
REQ-015 Port stat_clr  in  1  synchronous clear of the three counters.

Function
REQ-016 Storage: DEPTH entries of {dat, eop, err}; pointers wr_ptr, commit_ptr, rd_ptr are each log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
REQ-017 fill = wr_ptr - rd_ptr. full = (fill == DEPTH), computed from registered pointers only; a read in the same cycle does not free space for a write in that cycle.
REQ-018 Write FSM states: IDLE (between frames), RECV (frame in progress), DISCARD (drop the rest of a frame).
REQ-019 IDLE/RECV with i_val=1 and not full: store the word and increment wr_ptr. In IDLE with i_eop=0, go to RECV.
REQ-020 Eop, i_err=0: store the word; commit_ptr <= wr_ptr+1; stat_good_crc pulses; go to IDLE.
REQ-021 Eop, i_err=1, DROP_BAD=0: store the word and commit it as in REQ-020; stat_bad_crc pulses.
REQ-022 Eop, i_err=1, DROP_BAD=1: do not store; wr_ptr <= commit_ptr (rollback); stat_bad_crc pulses; go to IDLE.
REQ-023 i_val=1 while full (IDLE or RECV): do not store; wr_ptr <= commit_ptr; stat_fifo_ovfl pulses; go to DISCARD, or to IDLE if i_eop=1.
REQ-024 DISCARD: ignore every word; on i_val and i_eop go to IDLE. No good or bad pulse is produced for the truncated frame.
REQ-025 A frame longer than DEPTH words always overflows and is discarded per REQ-023.
REQ-026 Stat pulses are registered and assert exactly one cycle after the edge that samples the event.
REQ-027 Read side: o_val = (rd_ptr != commit_ptr). o_dat/o_eop/o_err come from the entry at rd_ptr. On o_val and o_rdy, rd_ptr increments.
REQ-028 Latency: the first word of a frame shows o_val=1 on the cycle after the edge that commits that frame's eop. Uncommitted words are never visible.
REQ-029 o_almostfull <= (fill >= DEPTH-AFULL_MARGIN), using post-update pointers, registered.
REQ-030 o_frames increments on each commit and decrements when an eop word is read; both in one cycle leaves it unchanged.
REQ-031 Counters increment with their pulses and saturate at 2^CNTW-1. If stat_clr coincides with an event, the counter loads 0; the clear wins.
REQ-032 Simultaneous commit and read are both honoured. A rollback never moves wr_ptr below rd_ptr, because commit_ptr is never behind rd_ptr.

Reset
REQ-033 reset=0 asynchronously sets: all pointers to 0, FSM to IDLE, o_val=0, o_almostfull=0, o_frames=0, all stat pulses 0, all counters 0. Storage contents are not reset.
REQ-034 Reset asserted mid-frame discards all stored and in-flight data. The first word after release starts a new frame.

Verification
REQ-035 4-word frame with good eop, o_rdy=1: o_val rises 1 cycle after the eop edge; words read out in order; stat_good_crc pulses once; cnt_good=1; o_frames goes 1 then 0.
REQ-036 DROP_BAD=1, 3-word frame with eop err=1, then a 2-word good frame: only the 2 good words are output; stat_bad_crc pulses once; cnt_bad=1.
REQ-037 DROP_BAD=0, same stimulus: all 5 words are output; o_err=1 only on the 3rd word.
REQ-038 DEPTH=8, o_rdy=0, 10-word frame then a 4-word good frame: overflow on word 9; frame 1 is discarded; stat_fifo_ovfl pulses once; the 4-word frame is stored and committed; o_frames=1.
REQ-039 DEPTH=8, AFULL_MARGIN=2, o_rdy=0, write 6 words: o_almostfull=1 one cycle after the 6th write; reading 1 word clears it.
REQ-040 Reset pulsed low after 2 words of a frame: o_val=0 and o_frames=0 during reset; a subsequent good frame is output intact.
